// File: rtl/tetris_pkg.sv
`default_nettype none
// ============================================================================
// Module   : tetris_pkg
// Purpose  : Shared playfield geometry, row types and the line_clear state
//            encoding.
// Revision : 1.0 - initial release
// ============================================================================
package tetris_pkg;

  localparam int ROWS = 20;  // playfield height, row 0 = top
  localparam int COLS = 10;  // playfield width = bits per row word

  typedef logic [$clog2(ROWS)-1:0] row_idx_t;
  typedef logic [COLS-1:0]         row_word_t;

  localparam row_word_t FULL_ROW  = '1;
  localparam row_word_t EMPTY_ROW = '0;

  typedef enum logic [2:0] {
    LC_IDLE  = 3'd0,
    LC_READ  = 3'd1,
    LC_CHECK = 3'd2,
    LC_FILL  = 3'd3,
    LC_DONE  = 3'd4,
    LC_HOLD  = 3'd5
  } lc_state_t;

endpackage : tetris_pkg
`default_nettype wire

// File: rtl/line_clear.sv
`default_nettype none
// ============================================================================
// Module   : line_clear
// Purpose  : CLEAR phase of the game loop. Scans the board bottom-to-top,
//            drops every full row, compacts surviving rows downward and
//            zero-fills the vacated rows at the top.
// Ports    : clka          - clock, all state on rising edge
//            restart_n     - asynchronous active-low reset
//            start_clear   - level request from the main controller
//            rd_row        - board read address (data returns 1 cycle later)
//            rd_data       - board read data
//            wr_en/wr_row/wr_data - board write port, one row per cycle
//            busy          - high from accepted start through done
//            done          - one-cycle completion pulse
//            lines_cleared - rows removed by the last operation
// Revision : 1.0 - initial release
// ============================================================================
module line_clear
  import tetris_pkg::*;
#(
  parameter int ROWS  = tetris_pkg::ROWS,
  parameter int COLS  = tetris_pkg::COLS,
  parameter int ROW_W = $clog2(ROWS),
  parameter int CNT_W = $clog2(ROWS + 1)
) (
  input  logic             clka,
  input  logic             restart_n,
  input  logic             start_clear,
  output logic [ROW_W-1:0] rd_row,
  input  logic [COLS-1:0]  rd_data,
  output logic             wr_en,
  output logic [ROW_W-1:0] wr_row,
  output logic [COLS-1:0]  wr_data,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] lines_cleared
);

  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(ROWS - 1);
  localparam logic [CNT_W-1:0] MAX_CNT  = CNT_W'(ROWS);

  lc_state_t        r_state, w_state_nx;
  logic [ROW_W-1:0] r_src,   w_src_nx;
  logic [ROW_W-1:0] r_dst,   w_dst_nx;
  logic [CNT_W-1:0] r_count, w_count_nx;
  logic [CNT_W-1:0] r_lines, w_lines_nx;
  logic             w_full;

  // The read address is simply the source pointer; in READ it points at the
  // row whose data arrives during the following CHECK cycle.
  assign rd_row        = r_src;
  assign lines_cleared = r_lines;
  assign w_full        = &rd_data;

  always_ff @(posedge clka or negedge restart_n) begin
    if (!restart_n) begin
      r_state <= LC_IDLE;
      r_src   <= '0;
      r_dst   <= '0;
      r_count <= '0;
      r_lines <= '0;
    end else begin
      r_state <= w_state_nx;
      r_src   <= w_src_nx;
      r_dst   <= w_dst_nx;
      r_count <= w_count_nx;
      r_lines <= w_lines_nx;
    end
  end

  always_comb begin
    w_state_nx = r_state;
    w_src_nx   = r_src;
    w_dst_nx   = r_dst;
    w_count_nx = r_count;
    w_lines_nx = r_lines;
    wr_en      = 1'b0;
    wr_row     = '0;
    wr_data    = '0;
    busy       = 1'b0;
    done       = 1'b0;

    case (r_state)
      LC_IDLE: begin
        if (start_clear) begin
          w_src_nx   = LAST_ROW;
          w_dst_nx   = LAST_ROW;
          w_count_nx = '0;
          w_lines_nx = '0;
          w_state_nx = LC_READ;
        end
      end

      LC_READ: begin
        busy       = 1'b1;
        w_state_nx = LC_CHECK;
      end

      LC_CHECK: begin
        busy = 1'b1;
        if (w_full) begin
          // dst stays put: the full row's slot will be refilled from above.
          if (r_count != MAX_CNT) begin
            w_count_nx = r_count + CNT_W'(1);
          end
        end else begin
          // Rows below the first full row are already in place.
          if (r_src != r_dst) begin
            wr_en   = 1'b1;
            wr_row  = r_dst;
            wr_data = rd_data;
          end
          if (r_dst != '0) begin
            w_dst_nx = r_dst - ROW_W'(1);
          end
        end

        if (r_src == '0) begin
          if (w_count_nx != '0) begin
            w_state_nx = LC_FILL;
          end else begin
            w_lines_nx = w_count_nx;
            w_state_nx = LC_DONE;
          end
        end else begin
          w_src_nx   = r_src - ROW_W'(1);
          w_state_nx = LC_READ;
        end
      end

      LC_FILL: begin
        // dst sits at count-1 here (or ROWS-1 when every row was full),
        // so walking down to row 0 writes exactly count empty rows.
        busy    = 1'b1;
        wr_en   = 1'b1;
        wr_row  = r_dst;
        wr_data = '0;
        if (r_dst == '0) begin
          w_lines_nx = r_count;
          w_state_nx = LC_DONE;
        end else begin
          w_dst_nx = r_dst - ROW_W'(1);
        end
      end

      LC_DONE: begin
        busy       = 1'b1;
        done       = 1'b1;
        w_state_nx = LC_HOLD;
      end

      LC_HOLD: begin
        // Wait for the controller to drop its level so one request
        // yields exactly one operation.
        if (!start_clear) begin
          w_state_nx = LC_IDLE;
        end
      end

      default: begin
        w_state_nx = LC_IDLE;
      end
    endcase
  end

endmodule : line_clear
`default_nettype wire

// File: tb/tb_line_clear.sv
`default_nettype none
// ============================================================================
// Module   : tb_line_clear
// Purpose  : Self-checking bench for line_clear with a 1-cycle-latency
//            behavioural board memory and an expectation queue.
// Revision : 1.0 - initial release
// ============================================================================
module tb_line_clear;

  localparam int NR = 20;
  localparam int NC = 10;

  typedef logic [NR-1:0][NC-1:0] brd_t;
  typedef struct packed {
    brd_t        board;
    logic [31:0] lc;
    logic [31:0] lat;
    logic [31:0] writes;
  } exp_t;

  logic          clka = 1'b0;
  logic          restart_n = 1'b0;
  logic          start_clear = 1'b0;
  logic [4:0]    rd_row;
  logic [NC-1:0] rd_data;
  logic          wr_en;
  logic [4:0]    wr_row;
  logic [NC-1:0] wr_data;
  logic          busy;
  logic          done;
  logic [4:0]    lines_cleared;

  logic [NC-1:0] mem [NR];
  logic          ld_en = 1'b0;
  logic [4:0]    ld_row = '0;
  logic [NC-1:0] ld_data = '0;

  int   n_pass = 0;
  int   n_fail = 0;
  int   n_total = 0;
  exp_t sb[$];

  line_clear dut (
    .clka          (clka),
    .restart_n     (restart_n),
    .start_clear   (start_clear),
    .rd_row        (rd_row),
    .rd_data       (rd_data),
    .wr_en         (wr_en),
    .wr_row        (wr_row),
    .wr_data       (wr_data),
    .busy          (busy),
    .done          (done),
    .lines_cleared (lines_cleared)
  );

  always #5 clka = ~clka;

  // Board memory: registered read, DUT write has priority over bench loads.
  always @(posedge clka) begin
    rd_data <= mem[rd_row];
    if (wr_en) mem[wr_row] <= wr_data;
    else if (ld_en) mem[ld_row] <= ld_data;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_total++;
    assert (obs === expv) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  task automatic chk_brd(input string tag, input brd_t obs, input brd_t expv);
    n_total++;
    assert (obs === expv) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  // Reference: survivors stack at the bottom in original order; writes are
  // every non-full row above the bottom-most full row plus one fill per
  // removed row.
  function automatic exp_t model(input brd_t b);
    exp_t e;
    int   k = 0;
    int   nfull = 0;
    int   bottom = -1;
    int   w;
    e.board = '0;
    for (int r = NR - 1; r >= 0; r--) begin
      if (&b[r]) begin
        nfull++;
        if (bottom < 0) bottom = r;
      end else begin
        e.board[NR-1-k] = b[r];
        k++;
      end
    end
    w = nfull;
    for (int r = 0; r < bottom; r++) if (!(&b[r])) w++;
    e.lc     = 32'(nfull);
    e.lat    = 32'(2 * NR + nfull + 1);
    e.writes = 32'(w);
    return e;
  endfunction

  task automatic load(input brd_t b);
    for (int i = 0; i < NR; i++) begin
      @(negedge clka);
      ld_en   = 1'b1;
      ld_row  = 5'(i);
      ld_data = b[i];
    end
    @(negedge clka);
    ld_en = 1'b0;
  endtask

  function automatic brd_t snap();
    brd_t s;
    for (int i = 0; i < NR; i++) s[i] = mem[i];
    return s;
  endfunction

  task automatic run_op(input string tag, input brd_t b, input bit drop_mid, input int hold_after);
    exp_t e;
    int   k = 0;
    int   w = 0;
    int   bad = 0;
    bit   seen = 1'b0;
    load(b);
    sb.push_back(model(b));
    @(negedge clka);
    start_clear = 1'b1;
    while (!seen && k < 200) begin
      @(negedge clka);
      k++;
      if (wr_en) w++;
      if (k == 1) chk({tag, "_busy_start"}, 32'(busy), 32'd1);
      if (drop_mid && k == 3) start_clear = 1'b0;
      if (done) seen = 1'b1;
    end
    chk({tag, "_done_seen"}, 32'(seen), 32'd1);
    e = sb.pop_front();
    chk({tag, "_latency"}, 32'(k), e.lat);
    chk({tag, "_lines"}, 32'(lines_cleared), e.lc);
    chk({tag, "_writes"}, 32'(w), e.writes);
    @(negedge clka);
    chk({tag, "_done_pulse"}, 32'(done), 32'd0);
    chk({tag, "_busy_after"}, 32'(busy), 32'd0);
    chk_brd({tag, "_board"}, snap(), e.board);
    repeat (hold_after) begin
      @(negedge clka);
      if (busy || done || wr_en) bad++;
    end
    if (hold_after > 0) chk({tag, "_hold_quiet"}, 32'(bad), 32'd0);
    start_clear = 1'b0;
    repeat (2) @(negedge clka);
    chk({tag, "_lines_held"}, 32'(lines_cleared), e.lc);
  endtask

  initial begin
    brd_t b_empty, b2, b3, b4, b5;
    int   bad;

    b_empty = '0;
    b2 = '0; b2[19] = '1; b2[18] = 10'h003;
    b3 = '0; b3[19] = '1; b3[18] = '1; b3[17] = '1; b3[16] = '1; b3[15] = 10'h2AA;
    b4 = '0; b4[19] = '1; b4[17] = '1; b4[18] = 10'h155; b4[16] = 10'h0AA;
    b5 = '1;

    // Reset state
    repeat (3) @(negedge clka);
    restart_n = 1'b1;
    #1;
    chk("rst_rd_row", 32'(rd_row), 32'd0);
    chk("rst_wr_en", 32'(wr_en), 32'd0);
    chk("rst_wr_row", 32'(wr_row), 32'd0);
    chk("rst_wr_data", 32'(wr_data), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_lines", 32'(lines_cleared), 32'd0);

    run_op("empty", b_empty, 1'b0, 0);
    run_op("one_full", b2, 1'b1, 0);       // start dropped mid-operation
    run_op("four_full", b3, 1'b0, 0);
    run_op("noncontig", b4, 1'b0, 0);
    run_op("all_full", b5, 1'b0, 10);      // start held 10 cycles past done

    // Reset in the middle of an operation
    load(b3);
    @(negedge clka);
    start_clear = 1'b1;
    repeat (15) @(negedge clka);
    restart_n = 1'b0;
    #1;
    chk("mid_rst_rd_row", 32'(rd_row), 32'd0);
    chk("mid_rst_wr_en", 32'(wr_en), 32'd0);
    chk("mid_rst_wr_row", 32'(wr_row), 32'd0);
    chk("mid_rst_wr_data", 32'(wr_data), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_done", 32'(done), 32'd0);
    chk("mid_rst_lines", 32'(lines_cleared), 32'd0);
    start_clear = 1'b0;
    repeat (2) @(negedge clka);
    restart_n = 1'b1;
    bad = 0;
    repeat (60) begin
      @(negedge clka);
      if (busy || done || wr_en) bad++;
    end
    chk("mid_rst_quiet", 32'(bad), 32'd0);

    run_op("post_reset", b2, 1'b0, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule : tb_line_clear
`default_nettype wire
